// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin bus arbiter with hold limit
// m0 (cpu) and m1 (debug loader) share one synchronous-memory slave port.
module bus_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic [3:0]    m0_writeb,
  input  logic          m0_read,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m1_req,
  input  logic [3:0]    m1_writeb,
  input  logic          m1_read,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [3:0]    s_writeb,
  output logic          s_read,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic [DW-1:0] s_rdata
);

  localparam int CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state;
  logic          last_owner;
  logic [CW-1:0] hold_cnt;
  logic          rd_owner;
  logic          rd_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      hold_cnt   <= '0;
      rd_owner   <= 1'b0;
      rd_pend    <= 1'b0;
    end else begin
      rd_pend <= s_read;
      if (s_read) rd_owner <= (state == OWN1);
      case (state)
        IDLE: begin
          hold_cnt <= '0;
          if (m0_req && m1_req) state <= last_owner ? OWN0 : OWN1;
          else if (m0_req)      state <= OWN0;
          else if (m1_req)      state <= OWN1;
        end
        OWN0: begin
          // Forced release takes priority over any req change this cycle.
          if (!m0_req || (hold_cnt == HOLD_MAX && m1_req)) begin
            state      <= IDLE;
            last_owner <= 1'b0;
          end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        OWN1: begin
          if (!m1_req || (hold_cnt == HOLD_MAX && m0_req)) begin
            state      <= IDLE;
            last_owner <= 1'b1;
          end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m0_gnt = (state == OWN0);
  assign m1_gnt = (state == OWN1);

  always_comb begin
    s_writeb = '0;
    s_read   = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    if (m0_gnt && m0_req) begin
      s_writeb = m0_writeb;
      s_read   = m0_read;
      s_addr   = m0_addr;
      s_wdata  = m0_wdata;
    end else if (m1_gnt && m1_req) begin
      s_writeb = m1_writeb;
      s_read   = m1_read;
      s_addr   = m1_addr;
      s_wdata  = m1_wdata;
    end
  end

  // Read data returns to whoever issued the read, even if the grant moved.
  assign m0_rvalid = rd_pend && !rd_owner;
  assign m1_rvalid = rd_pend && rd_owner;
  assign m0_rdata  = m0_rvalid ? s_rdata : '0;
  assign m1_rdata  = m1_rvalid ? s_rdata : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed bench for bus_arbiter with read-data scoreboard
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_read, m1_req, m1_read;
  logic [3:0]  m0_writeb, m1_writeb, s_writeb;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, s_read;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic [31:0] s_rdata = 32'h0;
  logic [31:0] mem [0:255];

  typedef struct packed {
    logic        owner;
    logic [31:0] data;
  } rd_exp_t;
  rd_exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int n;
  int excl;

  always #5 clk = ~clk;

  always @(posedge clk) if (s_read) s_rdata <= mem[s_addr[7:0]];

  bus_arbiter #(.AW(32), .DW(32), .MAX_HOLD(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_writeb(m0_writeb), .m0_read(m0_read),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_writeb(m1_writeb), .m1_read(m1_read),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .s_writeb(s_writeb), .s_read(s_read), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_rdata(s_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_check(input string tag);
    rd_exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_rvalid"}, e.owner ? m1_rvalid : m0_rvalid, 1);
      chk({tag, "_other"},  e.owner ? m0_rvalid : m1_rvalid, 0);
      chk({tag, "_rdata"},  e.owner ? m1_rdata  : m0_rdata,  e.data);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
    mem[8'h10] = 32'hdeadbeef;
    rst_n = 1'b0;
    m0_req = 0; m0_read = 0; m0_writeb = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_read = 0; m1_writeb = 0; m1_addr = 0; m1_wdata = 0;
    tick(); tick();
    chk("rst_gnt", {m0_gnt, m1_gnt}, 0);
    chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    chk("rst_strobes", {s_read, s_writeb}, 0);
    rst_n = 1'b1;

    // Single read by m0; strobes ignored until granted.
    m0_req = 1; m0_read = 1; m0_addr = 32'h10; #1;
    chk("pre_gnt_sread", s_read, 0);
    tick();
    chk("r_gnt0", {m0_gnt, m1_gnt}, 2'b10);
    chk("r_sread", s_read, 1);
    chk("r_saddr", s_addr, 32'h10);
    exp_q.push_back('{owner: 1'b0, data: 32'hdeadbeef});
    tick();
    rd_check("r_first");
    m0_read = 0; m0_req = 0;
    tick();
    chk("r_rvalid_off", {m0_rvalid, m1_rvalid}, 0);
    chk("r_rdata_zero", m0_rdata, 0);
    chk("r_idle", {m0_gnt, m1_gnt}, 0);

    // Round-robin after a fresh reset.
    rst_n = 0; tick(); rst_n = 1;
    m0_req = 1; m1_req = 1;
    tick();
    chk("rr_first_m0", {m0_gnt, m1_gnt}, 2'b10);
    m0_req = 0;
    tick();
    chk("rr_idle1", {m0_gnt, m1_gnt}, 0);
    tick();
    chk("rr_m1", {m0_gnt, m1_gnt}, 2'b01);
    m1_req = 0;
    tick();
    chk("rr_idle2", {m0_gnt, m1_gnt}, 0);
    m0_req = 1; m1_req = 1;
    tick();
    chk("rr_m0_again", {m0_gnt, m1_gnt}, 2'b10);
    m0_req = 0; m1_req = 0;
    tick();

    // Forced release of m1 after MAX_HOLD cycles (last_owner = 0 -> m1 wins tie).
    m0_req = 1; m1_req = 1;
    n = 0; excl = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (m0_gnt && m1_gnt) excl++;
      if (m1_gnt) n++;
      else if (n > 0) break;
    end
    chk("hold_cycles", n, 16);
    chk("hold_idle", {m0_gnt, m1_gnt}, 0);
    chk("hold_excl", excl, 0);
    tick();
    chk("hold_then_m0", {m0_gnt, m1_gnt}, 2'b10);
    m0_req = 0; m1_req = 0;
    tick();

    // m1 alone never gets forced off.
    m1_req = 1;
    tick();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (m1_gnt) n++;
      tick();
    end
    chk("solo_hold", n, 40);
    m1_req = 0;
    tick();

    // m0 read on its final owned cycle, m1 strobes ignored meanwhile.
    m0_addr = 32'h20; m1_addr = 32'h55; m1_writeb = 4'hf;
    m0_req = 1;
    tick();
    m1_req = 1;
    repeat (15) tick();
    chk("last_cycle_gnt0", m0_gnt, 1);
    chk("m1_wb_ignored", s_writeb, 0);
    m0_read = 1; #1;
    chk("last_saddr", s_addr, 32'h20);
    chk("last_sread", s_read, 1);
    exp_q.push_back('{owner: 1'b0, data: 32'hA500_0020});
    tick();
    rd_check("last_read");
    chk("forced_idle", {m0_gnt, m1_gnt}, 0);
    m0_read = 0;
    tick();
    chk("after_m1_gnt", {m0_gnt, m1_gnt}, 2'b01);
    chk("after_rvalid", {m0_rvalid, m1_rvalid}, 0);
    chk("m1_pass_wb", s_writeb, 4'hf);
    chk("m1_pass_addr", s_addr, 32'h55);
    m0_req = 0; m1_req = 0; m1_writeb = 0;
    tick();

    // Asynchronous reset with a read outstanding.
    m0_req = 1; m0_read = 1; m0_addr = 32'h10;
    tick();
    exp_q.push_back('{owner: 1'b0, data: 32'hdeadbeef});
    tick();
    rd_check("pre_reset_read");
    #2 rst_n = 0;
    #1;
    chk("async_gnt", {m0_gnt, m1_gnt}, 0);
    chk("async_rvalid", {m0_rvalid, m1_rvalid}, 0);
    chk("async_sread", s_read, 0);
    m0_read = 0; m0_req = 0;
    tick();
    rst_n = 1;
    m0_req = 1; m1_req = 1;
    tick();
    chk("post_reset_tie", {m0_gnt, m1_gnt}, 2'b10);
    m0_req = 0; m1_req = 0;
    tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter MAX_HOLD, default 16, max grant cycles while the other master waits; legal range 2..256.
REQ-004 SHALL have ports clk  input  1  sole clock, all state on posedge.
REQ-005 SHALL have ports rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have, per master x in {0,1} (m0 = cpu, m1 = debug loader): mx_req in 1; mx_writeb in 4; mx_read in 1; mx_addr in AW; mx_wdata in DW.
REQ-007 SHALL have, per master x: mx_gnt out 1; mx_rvalid out 1; mx_rdata out DW.
REQ-008 SHALL have slave ports s_writeb out 4; s_read out 1; s_addr out AW; s_wdata out DW; s_rdata in DW (synchronous memory, data valid one cycle after s_read).

Function
REQ-009 SHALL implement states IDLE, OWN0, OWN1, with a registered last_owner bit.
REQ-010 In IDLE with only mx_req high at a posedge, the block SHALL enter OWNx; mx_gnt = 1 from the cycle after the edge.
REQ-011 In IDLE with both req high, the block SHALL grant the master that is not last_owner (round-robin).
REQ-012 In OWNx, mx_gnt SHALL be 1; the other gnt SHALL be 0; gnt0 and gnt1 SHALL never both be 1.
REQ-013 In OWNx with mx_req high, s_writeb, s_read, s_addr and s_wdata SHALL pass mx_* combinationally.
REQ-014 Otherwise, s_writeb SHALL be 0, s_read 0, s_addr 0 and s_wdata 0.
REQ-015 In OWNx, mx_req low at a posedge SHALL return to IDLE and set last_owner = x; there is no back-to-back re-grant without an IDLE cycle.
REQ-016 The hold counter ($clog2(MAX_HOLD) bits) SHALL be cleared on entering OWNx and increment each OWNx cycle, saturating at MAX_HOLD-1.
REQ-017 In OWNx at a posedge with counter == MAX_HOLD-1 and the other req high, the block SHALL force IDLE with last_owner = x, so the other master wins the next cycle.
REQ-018 Without a competing request, the owner SHALL hold the grant indefinitely.
REQ-019 A read is accepted at a posedge where s_read = 1; the accepting owner SHALL be recorded in register rd_owner.
REQ-020 mx_rvalid SHALL be 1 for exactly the cycle after acceptance, for x == rd_owner only, even if the grant has since dropped or moved.
REQ-021 mx_rdata SHALL equal s_rdata while mx_rvalid = 1, and 0 otherwise.
REQ-022 Writes complete at the accepting posedge; no write acknowledge is produced.
REQ-023 mx_writeb or mx_read asserted without mx_gnt SHALL be ignored, with no side effect.
REQ-024 A req change in the same cycle as a forced release SHALL be resolved by REQ-017, then REQ-011 in the following IDLE.

Reset
REQ-025 While rst_n = 0: state IDLE, last_owner = 1 (m0 wins the first tie), counter 0, rd_owner 0, both gnt 0, both rvalid 0, all s_* strobes 0.
REQ-026 Reset mid-transaction SHALL drop the grant and any pending rvalid immediately, without waiting for a clock.
REQ-027 The first grant SHALL follow the first posedge after rst_n rises.

Verification
REQ-028 m0 req + read at addr 0x10, memory word 0xdeadbeef -> gnt0 next cycle, s_read = 1, m0_rvalid one cycle later with m0_rdata = 0xdeadbeef, m1_rvalid = 0.
REQ-029 Both req rise together after reset -> m0 granted; m0 drops req -> 1 IDLE cycle -> m1 granted; m1 drops, both re-request -> m0 granted.
REQ-030 m1 granted with req held and m0 requesting -> m1_gnt high exactly 16 cycles, 1 IDLE cycle, then m0_gnt.
REQ-031 m1 alone holding req for 40 cycles -> m1_gnt stays high all 40 cycles, no forced release.
REQ-032 m0 read accepted on its last owned cycle, m1 granted afterwards -> m0_rvalid pulse with correct data, m1_rvalid = 0.
REQ-033 rst_n pulsed low mid-grant with a read pending -> gnt and rvalid drop asynchronously; after release, a tie grants m0.
